// File: rtl/branch_predict_resolve.sv
// Branch unit for the pipelined MIPS core: 2-bit BHT prediction at fetch, branch resolve at
// execute with BHT training, registered one-cycle redirect and saturating statistics.
module branch_predict_resolve #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned BHT_DEPTH = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] fetch_pc,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic             ex_flush,
    input  logic [5:0]       ex_opcode,
    input  logic [4:0]       ex_rt,
    input  logic [WIDTH-1:0] ex_pc,
    input  logic [WIDTH-1:0] ex_target,
    input  logic             ex_pred_taken,
    input  logic [WIDTH-1:0] Da,
    input  logic [WIDTH-1:0] Db,
    output logic             redirect,
    output logic [WIDTH-1:0] redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    logic [1:0]       bht_q [BHT_DEPTH];
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             is_branch;
    logic             taken;
    logic             resolve;
    logic             mispredict;
    logic             da_neg;
    logic             da_zero;
    logic             unused_pc_bits;

    assign fetch_idx = fetch_pc[IDX_W+1:2];
    assign ex_idx    = ex_pc[IDX_W+1:2];

    // No bypass: a same-cycle update to this index is visible only after the edge.
    assign pred_taken = bht_q[fetch_idx][1];

    assign unused_pc_bits = ^{fetch_pc[WIDTH-1:IDX_W+2], fetch_pc[1:0]};

    assign da_neg  = Da[WIDTH-1];
    assign da_zero = (Da == '0);

    always_comb begin
        is_branch = 1'b0;
        taken     = 1'b0;
        case (ex_opcode)
            OP_BEQ: begin
                is_branch = 1'b1;
                taken     = (Da == Db);
            end
            OP_BNE: begin
                is_branch = 1'b1;
                taken     = (Da != Db);
            end
            OP_BLEZ: begin
                is_branch = 1'b1;
                taken     = da_neg | da_zero;
            end
            OP_BGTZ: begin
                is_branch = 1'b1;
                taken     = ~da_neg & ~da_zero;
            end
            OP_REGIMM: begin
                if (ex_rt == 5'b00000) begin
                    is_branch = 1'b1;
                    taken     = da_neg;
                end else if (ex_rt == 5'b00001) begin
                    is_branch = 1'b1;
                    taken     = ~da_neg;
                end
            end
            default: begin
                is_branch = 1'b0;
                taken     = 1'b0;
            end
        endcase
    end

    assign resolve    = ex_valid & ~ex_flush & is_branch;
    assign mispredict = resolve & (taken != ex_pred_taken);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(BHT_DEPTH); i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (resolve) begin
            if (taken && bht_q[ex_idx] != 2'b11) begin
                bht_q[ex_idx] <= bht_q[ex_idx] + 2'b01;
            end else if (!taken && bht_q[ex_idx] != 2'b00) begin
                bht_q[ex_idx] <= bht_q[ex_idx] - 2'b01;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            redirect <= mispredict;
            if (mispredict) begin
                redirect_pc <= taken ? ex_target : ex_pc + WIDTH'(4);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (resolve && branch_count != '1) begin
                branch_count <= branch_count + CNT_W'(1);
            end
            if (mispredict && mispredict_count != '1) begin
                mispredict_count <= mispredict_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Bench for branch_predict_resolve: directed plan steps followed by randomized branches,
// all compared against a behavioural model of the BHT, redirect and counters.
module tb_branch_predict_resolve;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = 4;
    localparam int          CMAX  = 15;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] fetch_pc;
    logic             pred_taken;
    logic             ex_valid;
    logic             ex_flush;
    logic [5:0]       ex_opcode;
    logic [4:0]       ex_rt;
    logic [WIDTH-1:0] ex_pc;
    logic [WIDTH-1:0] ex_target;
    logic             ex_pred_taken;
    logic [WIDTH-1:0] Da;
    logic [WIDTH-1:0] Db;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    int checks;
    int failures;

    // Reference state
    int          m_bht [DEPTH];
    int          m_bc;
    int          m_mc;
    bit          m_red;
    logic [31:0] m_rpc;

    branch_predict_resolve #(
        .WIDTH(WIDTH),
        .BHT_DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fetch_pc(fetch_pc),
        .pred_taken(pred_taken),
        .ex_valid(ex_valid),
        .ex_flush(ex_flush),
        .ex_opcode(ex_opcode),
        .ex_rt(ex_rt),
        .ex_pc(ex_pc),
        .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken),
        .Da(Da),
        .Db(Db),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .branch_count(branch_count),
        .mispredict_count(mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    // Branch semantics from the ISA description, using signed integer arithmetic.
    task automatic outcome(input logic [5:0] op, input logic [4:0] rt, input logic [31:0] a,
                           input logic [31:0] b, output bit isb, output bit tk);
        int sa;
        sa  = signed'(a);
        isb = 1'b1;
        tk  = 1'b0;
        if (op == 6'd4) tk = (a == b);
        else if (op == 6'd5) tk = (a != b);
        else if (op == 6'd6) tk = (sa <= 0);
        else if (op == 6'd7) tk = (sa > 0);
        else if (op == 6'd1 && rt == 5'd0) tk = (sa < 0);
        else if (op == 6'd1 && rt == 5'd1) tk = (sa >= 0);
        else isb = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) m_bht[i] = 1;
        m_bc  = 0;
        m_mc  = 0;
        m_red = 1'b0;
        m_rpc = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset    = 1'b1;
        ex_valid = 1'b0;
        ex_flush = 1'b0;
        model_reset();
        #1;
        check("reset_redirect", {31'd0, redirect}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_redirect"}, {31'd0, redirect}, {31'd0, m_red});
        check({tag, "_redirect_pc"}, redirect_pc, m_rpc);
        check({tag, "_branch_count"}, 32'(branch_count), 32'(m_bc));
        check({tag, "_mispredict_count"}, 32'(mispredict_count), 32'(m_mc));
    endtask

    task automatic check_pred(input string tag, input logic [31:0] fpc);
        fetch_pc = fpc;
        #1;
        check(tag, {31'd0, pred_taken}, {31'd0, m_bht[idx_of(fpc)] >= 2});
    endtask

    // Presents one execute-stage instruction for one cycle and checks everything around it.
    task automatic run_branch(input string tag, input bit v, input bit f, input logic [5:0] op,
                              input logic [4:0] rt, input logic [31:0] pc,
                              input logic [31:0] tgt, input bit pt, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] fpc);
        bit isb, tk;
        int i;
        ex_valid      = v;
        ex_flush      = f;
        ex_opcode     = op;
        ex_rt         = rt;
        ex_pc         = pc;
        ex_target     = tgt;
        ex_pred_taken = pt;
        Da            = a;
        Db            = b;
        check_pred({tag, "_pred_pre"}, fpc);
        outcome(op, rt, a, b, isb, tk);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        if (v && !f && isb) begin
            i = idx_of(pc);
            m_bht[i] = tk ? (m_bht[i] < 3 ? m_bht[i] + 1 : 3) : (m_bht[i] > 0 ? m_bht[i] - 1 : 0);
            m_bc = (m_bc < CMAX) ? m_bc + 1 : CMAX;
            if (tk != pt) begin
                m_red = 1'b1;
                m_rpc = tk ? tgt : pc + 32'd4;
                m_mc  = (m_mc < CMAX) ? m_mc + 1 : CMAX;
            end else begin
                m_red = 1'b0;
            end
        end else begin
            m_red = 1'b0;
        end
        check_state(tag);
        check_pred({tag, "_pred_post"}, fpc);
    endtask

    task automatic idle(input string tag);
        run_branch(tag, 1'b0, 1'b0, 6'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h40);
    endtask

    initial begin
        logic [5:0]  op;
        logic [4:0]  rt;
        logic [31:0] a, b, pc;
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        fetch_pc      = '0;
        ex_valid      = 1'b0;
        ex_flush      = 1'b0;
        ex_opcode     = '0;
        ex_rt         = '0;
        ex_pc         = '0;
        ex_target     = '0;
        ex_pred_taken = 1'b0;
        Da            = '0;
        Db            = '0;
        model_reset();

        // Reset then read
        do_reset();
        fetch_pc = 32'h40;
        #1;
        check("rst_pred", {31'd0, pred_taken}, 32'd0);
        check("rst_redirect", {31'd0, redirect}, 32'd0);
        check("rst_bc", 32'(branch_count), 32'd0);
        check("rst_mc", 32'(mispredict_count), 32'd0);

        // Mispredicted taken BEQ; fetch at same index sees the old entry until the edge
        run_branch("beq_mis", 1, 0, 6'd4, 5'd0, 32'h100, 32'h200, 0, 32'd5, 32'd5, 32'h100);
        check("beq_mis_rpc_const", redirect_pc, 32'h200);
        check("beq_mis_pred_const", {31'd0, pred_taken}, 32'd1);
        idle("beq_after");
        check("beq_after_redirect", {31'd0, redirect}, 32'd0);
        check("beq_after_rpc_hold", redirect_pc, 32'h200);

        // Correct not-taken BNE, twice to bottom out the entry
        run_branch("bne_ok1", 1, 0, 6'd5, 5'd0, 32'h104, 32'h300, 0, 32'd7, 32'd7, 32'h104);
        run_branch("bne_ok2", 1, 0, 6'd5, 5'd0, 32'h104, 32'h300, 0, 32'd7, 32'd7, 32'h104);
        check("bne_bc_const", 32'(branch_count), 32'd3);
        check("bne_mc_const", 32'(mispredict_count), 32'd1);
        // 00 -> 01 keeps not-taken; a stuck-at-01 entry would flip on the next one
        run_branch("bne_up1", 1, 0, 6'd5, 5'd0, 32'h104, 32'h300, 0, 32'd1, 32'd2, 32'h104);
        check("bne_up1_pred_const", {31'd0, pred_taken}, 32'd0);

        // Signed and REGIMM types, predicted opposite so the outcome shows in redirect
        run_branch("blez_neg", 1, 0, 6'd6, 5'd0, 32'h10, 32'h500, 0, 32'hFFFFFFFF, 0, 32'h10);
        check("blez_neg_rpc_const", redirect_pc, 32'h500);
        run_branch("bgtz_zero", 1, 0, 6'd7, 5'd0, 32'h14, 32'h600, 1, 32'h0, 0, 32'h14);
        check("bgtz_zero_rpc_const", redirect_pc, 32'h18);
        run_branch("bltz_min", 1, 0, 6'd1, 5'd0, 32'h18, 32'h700, 0, 32'h80000000, 0, 32'h18);
        check("bltz_min_rpc_const", redirect_pc, 32'h700);
        run_branch("bgez_zero", 1, 0, 6'd1, 5'd1, 32'h1C, 32'h800, 0, 32'h0, 0, 32'h1C);
        check("bgez_zero_rpc_const", redirect_pc, 32'h800);
        run_branch("regimm_rt2", 1, 0, 6'd1, 5'd2, 32'h20, 32'h900, 1, 32'h0, 0, 32'h20);
        check("regimm_rt2_redirect_const", {31'd0, redirect}, 32'd0);

        // BHT saturation at taken
        for (int k = 0; k < 4; k++) begin
            run_branch("sat_taken", 1, 0, 6'd4, 5'd0, 32'h300, 32'h80, 1, 32'd3, 32'd3, 32'h300);
        end
        run_branch("sat_down", 1, 0, 6'd4, 5'd0, 32'h300, 32'h80, 1, 32'd3, 32'd4, 32'h300);
        check("sat_down_pred_const", {31'd0, pred_taken}, 32'd1);

        // Counter saturation and PC wrap
        for (int k = 0; k < 20; k++) begin
            run_branch("cnt_mis", 1, 0, 6'd5, 5'd0, 32'h200, 32'h44, 0, 32'd1, 32'd2, 32'h0);
        end
        check("cnt_bc_sat_const", 32'(branch_count), 32'hF);
        check("cnt_mc_sat_const", 32'(mispredict_count), 32'hF);
        run_branch("wrap", 1, 0, 6'd4, 5'd0, 32'hFFFFFFFC, 32'h44, 1, 32'd1, 32'd2, 32'h0);
        check("wrap_rpc_const", redirect_pc, 32'h0);
        check("wrap_redirect_const", {31'd0, redirect}, 32'd1);

        // Flush blocks a mispredicting BEQ
        do_reset();
        run_branch("flush", 1, 1, 6'd4, 5'd0, 32'h100, 32'h200, 0, 32'd5, 32'd5, 32'h100);
        check("flush_redirect_const", {31'd0, redirect}, 32'd0);
        check("flush_bc_const", 32'(branch_count), 32'd0);

        // Async reset drops a live redirect without a clock edge
        run_branch("pre_async", 1, 0, 6'd4, 5'd0, 32'h100, 32'h200, 0, 32'd5, 32'd5, 32'h100);
        check("pre_async_redirect_const", {31'd0, redirect}, 32'd1);
        reset = 1'b1;
        #1;
        check("async_redirect", {31'd0, redirect}, 32'd0);
        check("async_rpc", redirect_pc, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_pred("async_pred", 32'h100);

        // Randomized branches against the model
        do_reset();
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 7))
                0: op = 6'd4;
                1: op = 6'd5;
                2: op = 6'd6;
                3: op = 6'd7;
                4, 5: op = 6'd1;
                6: op = 6'd0;
                default: op = 6'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0: rt = 5'd0;
                1: rt = 5'd1;
                2: rt = 5'd2;
                default: rt = 5'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0: a = 32'h0;
                1: a = 32'hFFFFFFFF;
                2: a = 32'h80000000;
                3: a = 32'd1;
                default: a = $urandom;
            endcase
            b  = ($urandom_range(0, 2) == 0) ? a : $urandom_range(0, 3);
            pc = ($urandom_range(0, 9) == 0) ? ($urandom & 32'hFFFFFFFC)
                                             : {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            run_branch("rand", $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2, op, rt, pc,
                       $urandom, 1'($urandom), a, b,
                       ($urandom_range(0, 1) == 1) ? pc : {26'd0, 4'($urandom), 2'b00});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
